// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle RV32I sequencer sharing one memory port
module multi_cycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [6:0]           opCode,
  input  logic                 aluZero,
  input  logic                 memReady,
  output logic                 memReq,
  output logic                 memWe,
  output logic                 iorSel,
  output logic                 irWrite,
  output logic                 pcWrite,
  output logic                 pcSrc,
  output logic                 aluSrc,
  output logic                 memToReg,
  output logic                 regWrite,
  output logic                 branch,
  output logic [1:0]           aluOp,
  output logic                 trap,
  output logic [1:0]           trapCause,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instRetired
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_R    = 3'd1,
    C_I    = 3'd2,
    C_L    = 3'd3,
    C_S    = 3'd4,
    C_B    = 3'd5,
    C_ILL  = 3'd6
  } cls_t;

  localparam logic [15:0] TMO_LIMIT = 16'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] RET_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t      cur_state, next_state;
  cls_t        cls_q, cls_d, dec_cls;
  logic [15:0] tmo_cnt, tmo_d;
  logic [1:0]  cause_q, cause_d;
  logic        timed_out;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cur_state   <= S_FETCH;
      cls_q       <= C_NONE;
      tmo_cnt     <= 16'd0;
      cause_q     <= 2'b00;
      instRetired <= '0;
    end else begin
      cur_state <= next_state;
      cls_q     <= cls_d;
      tmo_cnt   <= tmo_d;
      cause_q   <= cause_d;
      if (pcWrite) begin
        instRetired <= instRetired + RET_ONE;
      end
    end
  end

  always_comb begin
    dec_cls = C_ILL;
    case (opCode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_L;
      7'b0100011: dec_cls = C_S;
      7'b1100011: dec_cls = C_B;
      default:    dec_cls = C_ILL;
    endcase
  end

  // A ready response on the limit cycle takes priority over the timeout.
  assign timed_out = (tmo_cnt == TMO_LIMIT) && !memReady;

  always_comb begin
    next_state = cur_state;
    cls_d      = cls_q;
    cause_d    = cause_q;
    memReq     = 1'b0;
    memWe      = 1'b0;
    iorSel     = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 1'b0;
    aluSrc     = 1'b0;
    memToReg   = 1'b0;
    regWrite   = 1'b0;
    branch     = 1'b0;
    aluOp      = 2'b00;
    case (cur_state)
      S_FETCH: begin
        memReq = 1'b1;
        if (memReady) begin
          irWrite    = 1'b1;
          next_state = S_DECODE;
        end else if (timed_out) begin
          next_state = S_TRAP;
          cause_d    = 2'b10;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == C_ILL) begin
          next_state = S_TRAP;
          cause_d    = 2'b01;
        end else begin
          next_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (cls_q)
          C_R: begin
            aluOp      = 2'b10;
            next_state = S_WRITEBACK;
          end
          C_I: begin
            aluSrc     = 1'b1;
            aluOp      = 2'b11;
            next_state = S_WRITEBACK;
          end
          C_L, C_S: begin
            aluSrc     = 1'b1;
            next_state = S_MEMORY;
          end
          C_B: begin
            aluOp      = 2'b01;
            branch     = 1'b1;
            pcWrite    = 1'b1;
            pcSrc      = aluZero;
            next_state = S_FETCH;
          end
          default: begin
            next_state = S_TRAP;
            cause_d    = 2'b01;
          end
        endcase
      end
      S_MEMORY: begin
        memReq = 1'b1;
        iorSel = 1'b1;
        memWe  = (cls_q == C_S);
        aluSrc = 1'b1;
        if (memReady) begin
          if (cls_q == C_S) begin
            pcWrite    = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WRITEBACK;
          end
        end else if (timed_out) begin
          next_state = S_TRAP;
          cause_d    = 2'b10;
        end
      end
      S_WRITEBACK: begin
        regWrite   = 1'b1;
        memToReg   = (cls_q == C_L);
        pcWrite    = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP: begin
        next_state = S_TRAP;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
    // Reset must drop the memory request immediately, not at the next edge.
    if (!rstN) begin
      memReq   = 1'b0;
      memWe    = 1'b0;
      iorSel   = 1'b0;
      irWrite  = 1'b0;
      pcWrite  = 1'b0;
      pcSrc    = 1'b0;
      aluSrc   = 1'b0;
      memToReg = 1'b0;
      regWrite = 1'b0;
      branch   = 1'b0;
      aluOp    = 2'b00;
    end
  end

  always_comb begin
    tmo_d = 16'd0;
    if (next_state == cur_state && !memReady && memReq) begin
      tmo_d = tmo_cnt + 16'd1;
    end
  end

  assign trap      = (cur_state == S_TRAP);
  assign trapCause = cause_q;
  assign state     = cur_state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - scoreboard bench for the multi-cycle sequencer
module tb_multi_cycle_control;

  logic        clk = 1'b0;
  logic        rstN;
  logic [6:0]  opCode;
  logic        aluZero;
  logic        memReady;
  logic        memReq, memWe, iorSel, irWrite, pcWrite, pcSrc;
  logic        aluSrc, memToReg, regWrite, branch, trap;
  logic [1:0]  aluOp, trapCause;
  logic [2:0]  state;
  logic [31:0] instRetired;

  always #5 clk = ~clk;

  multi_cycle_control #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rstN(rstN), .opCode(opCode), .aluZero(aluZero),
    .memReady(memReady), .memReq(memReq), .memWe(memWe), .iorSel(iorSel),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .aluSrc(aluSrc),
    .memToReg(memToReg), .regWrite(regWrite), .branch(branch), .aluOp(aluOp),
    .trap(trap), .trapCause(trapCause), .state(state), .instRetired(instRetired)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [11:0] ctl;
    logic        trp;
    logic [1:0]  cause;
    logic [31:0] ret;
  } obs_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  obs_t        exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        exp_trap;
  logic [1:0]  exp_cause;
  logic [31:0] exp_ret;
  logic [6:0]  cur_op;
  logic        cur_zero;
  logic        idle_rdy;
  obs_t        mon_e, mon_a;
  string       mon_nm;

  // ctl bit order: memReq memWe iorSel irWrite pcWrite pcSrc aluSrc memToReg regWrite branch aluOp[1:0]
  function automatic logic [11:0] mk(input logic req, input logic we, input logic ior,
                                     input logic irw, input logic pcw, input logic pcs,
                                     input logic asrc, input logic m2r, input logic rw,
                                     input logic br, input logic [1:0] aop);
    return {req, we, ior, irw, pcw, pcs, asrc, m2r, rw, br, aop};
  endfunction

  task automatic cyc(input logic rst, input logic rdy, input string nm,
                     input logic [2:0] st, input logic [11:0] ctl);
    @(posedge clk);
    #1;
    rstN     = rst;
    memReady = rdy;
    opCode   = cur_op;
    aluZero  = cur_zero;
    if (!rst) begin
      exp_trap  = 1'b0;
      exp_cause = 2'b00;
      exp_ret   = 32'd0;
    end
    exp_q.push_back({st, ctl, exp_trap, exp_cause, exp_ret});
    name_q.push_back(nm);
    if (rst && ctl[7]) exp_ret = exp_ret + 32'd1;
  endtask

  task automatic fetch(input int waits, input string tag);
    for (int i = 0; i < waits; i++)
      cyc(1'b1, 1'b0, {tag, "_fetch_wait"}, 3'd0, mk(1,0,0,0,0,0,0,0,0,0,2'b00));
    cyc(1'b1, 1'b1, {tag, "_fetch"}, 3'd0, mk(1,0,0,1,0,0,0,0,0,0,2'b00));
  endtask

  task automatic run(input logic [6:0] op, input logic zero, input int wf,
                     input int wm, input string tag);
    logic is_s;
    cur_op   = op;
    cur_zero = zero;
    is_s     = (op == OP_S);
    fetch(wf, tag);
    cyc(1'b1, idle_rdy, {tag, "_decode"}, 3'd1, 12'd0);
    // The class was latched in DECODE, so a garbage opcode from here on must not matter.
    cur_op = ~op;
    if (op == OP_R) begin
      cyc(1'b1, idle_rdy, {tag, "_exec"}, 3'd2, mk(0,0,0,0,0,0,0,0,0,0,2'b10));
      cyc(1'b1, idle_rdy, {tag, "_wb"}, 3'd4, mk(0,0,0,0,1,0,0,0,1,0,2'b00));
    end else if (op == OP_I) begin
      cyc(1'b1, idle_rdy, {tag, "_exec"}, 3'd2, mk(0,0,0,0,0,0,1,0,0,0,2'b11));
      cyc(1'b1, idle_rdy, {tag, "_wb"}, 3'd4, mk(0,0,0,0,1,0,0,0,1,0,2'b00));
    end else if (op == OP_B) begin
      cyc(1'b1, idle_rdy, {tag, "_exec"}, 3'd2, mk(0,0,0,0,1,zero,0,0,0,1,2'b01));
    end else begin
      cyc(1'b1, idle_rdy, {tag, "_exec"}, 3'd2, mk(0,0,0,0,0,0,1,0,0,0,2'b00));
      for (int i = 0; i < wm; i++)
        cyc(1'b1, 1'b0, {tag, "_mem_wait"}, 3'd3, mk(1,is_s,1,0,0,0,1,0,0,0,2'b00));
      cyc(1'b1, 1'b1, {tag, "_mem"}, 3'd3, mk(1,is_s,1,0,is_s,0,1,0,0,0,2'b00));
      if (!is_s)
        cyc(1'b1, idle_rdy, {tag, "_wb"}, 3'd4, mk(0,0,0,0,1,0,0,1,1,0,2'b00));
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      mon_a  = {state, memReq, memWe, iorSel, irWrite, pcWrite, pcSrc, aluSrc,
                memToReg, regWrite, branch, aluOp, trap, trapCause, instRetired};
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL %s: got st=%0d ctl=%03h trap=%0b cause=%0d ret=%0d, expected st=%0d ctl=%03h trap=%0b cause=%0d ret=%0d",
                 mon_nm, mon_a.st, mon_a.ctl, mon_a.trp, mon_a.cause, mon_a.ret,
                 mon_e.st, mon_e.ctl, mon_e.trp, mon_e.cause, mon_e.ret);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rstN      = 1'b0;
    opCode    = 7'd0;
    aluZero   = 1'b0;
    memReady  = 1'b0;
    exp_trap  = 1'b0;
    exp_cause = 2'b00;
    exp_ret   = 32'd0;
    cur_op    = 7'd0;
    cur_zero  = 1'b0;
    idle_rdy  = 1'b0;

    cyc(1'b0, 1'b0, "reset", 3'd0, 12'd0);
    cyc(1'b0, 1'b1, "reset_rdy", 3'd0, 12'd0);

    idle_rdy = 1'b1;
    run(OP_R, 1'b0, 0, 0, "r");
    idle_rdy = 1'b0;
    run(OP_I, 1'b0, 1, 0, "i");
    run(OP_L, 1'b0, 3, 3, "ld");

    cyc(1'b0, 1'b0, "reset2", 3'd0, 12'd0);
    run(OP_S, 1'b0, 0, 0, "st");
    run(OP_B, 1'b1, 0, 0, "b_taken");
    run(OP_B, 1'b0, 0, 0, "b_fall");

    cur_op = OP_L;
    fetch(0, "abort");
    cyc(1'b1, 1'b0, "abort_decode", 3'd1, 12'd0);
    cyc(1'b1, 1'b0, "abort_exec", 3'd2, mk(0,0,0,0,0,0,1,0,0,0,2'b00));
    cyc(1'b1, 1'b0, "abort_mem_wait", 3'd3, mk(1,0,1,0,0,0,1,0,0,0,2'b00));
    cyc(1'b0, 1'b1, "abort_async_reset", 3'd0, 12'd0);

    cur_op = 7'b1111111;
    fetch(1, "ill");
    cyc(1'b1, 1'b0, "ill_decode", 3'd1, 12'd0);
    exp_trap  = 1'b1;
    exp_cause = 2'b01;
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 1'(i % 2), "ill_trap", 3'd7, 12'd0);

    cyc(1'b0, 1'b0, "reset3", 3'd0, 12'd0);
    cur_op = OP_R;
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b0, "tmo_wait", 3'd0, mk(1,0,0,0,0,0,0,0,0,0,2'b00));
    exp_trap  = 1'b1;
    exp_cause = 2'b10;
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, "tmo_trap", 3'd7, 12'd0);

    cyc(1'b0, 1'b0, "reset4", 3'd0, 12'd0);
    run(OP_R, 1'b0, 4, 0, "tmo_edge");
    run(OP_L, 1'b0, 0, 4, "tmo_edge_mem");

    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
